obi_cfg_initiator: RTL and testbench
====================================

Name: obi_cfg_initiator

Overview:
- OBI initiator (master) that drives register-access transactions into the cache controller's configuration register slave (for example, GPU start).
- Accepts simple single-beat commands from a host-side sequencer or debug port, and issues them on the OBI request/response interface.
- Only one transaction is outstanding at a time. The result is returned with a valid/ready handshake.
- A bounded timeout guarantees forward progress if the slave never grants or never responds.

Parameters:
- TIMEOUT_CYCLES, 256: cycles allowed in each of REQ and WAIT_RSP before an error is reported; must be >= 2.
- ERR_RDATA, 32'hBADCAB1E: value returned on rsp_rdata_o on timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  32  byte address
- cmd_wdata_i  in  32  write data
- cmd_be_i  in  4  byte enables
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result consumed
- rsp_rdata_o  out  32  read data (0 for writes, ERR_RDATA on timeout)
- rsp_err_o  out  1  timeout occurred
- busy_o  out  1  state != IDLE
- regs_req  obi_req_if.master  -  req, we, be, addr, wdata out; gnt in
- regs_rsp  obi_rsp_if.slave  -  rvalid, rdata in

Behaviour:
- Reset (async, rst_i=1): state=IDLE; cmd_ready_o=1 once reset is released.
  - Outputs forced to 0: rsp_valid_o, rsp_err_o, rsp_rdata_o, busy_o, regs_req.req/we/be/addr/wdata.
  - Timeout counter cleared.
  - Reset mid-transaction abandons the transaction; nothing is replayed.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i && cmd_ready_o: register we, be, addr (with addr[1:0] forced to 0), and wdata into the request regs; clear counter; go to REQ.
- REQ:
  - regs_req.req=1; bus fields come straight from the request regs and are stable while req=1.
  - gnt=1 (combinational, same cycle): go to WAIT_RSP, clear counter; req drops in the next cycle.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 with no gnt: drop req, set err, load ERR_RDATA, go to RESP.
- WAIT_RSP:
  - req=0.
  - On rvalid: capture rdata if the transaction is a read, else 0; err=0; go to RESP.
  - Otherwise the counter increments, with the same timeout rule as REQ.
  - rvalid arriving in the same cycle as the timeout wins: the response is accepted and no error is flagged.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o are held stable.
  - On rsp_ready_i: go to IDLE.
  - cmd_ready_o=0 until the state returns to IDLE, so a new command is accepted at the earliest in the cycle after the response handshake.
- rvalid seen in IDLE, REQ or RESP: ignored, with no state change.
- Latency against a zero-wait slave (gnt in the same cycle as req, rvalid one cycle later), counted from the command handshake edge N:
  - req high in cycle N+1;
  - rvalid in cycle N+2;
  - rsp_valid_o high in cycle N+3.
- Timeout counter: $clog2(TIMEOUT_CYCLES) bits wide; saturates and never wraps.

Decomposition:
- Package e_gpu_obi_pkg:
  - state_t enum {IDLE, REQ, WAIT_RSP, RESP}, 2 bits;
  - default ERR_RDATA constant;
  - cmd_t struct {we, be, addr, wdata}.
- One sub-module: obi_timeout_cnt. Inputs: clk_i, rst_i, clr, en. Output: expired. Parameter: TIMEOUT_CYCLES.

Test Plan:
- Write, zero-wait slave: write addr=0x0, wdata=0x1, be=0xF → req in N+1 with addr=0x0, we=1, be=0xF; rsp_valid_o in N+3 with rdata=0, err=0; slave GPU start output =1.
- Read-back: read addr=0x0 after the write above → rsp_rdata_o=0x00000001, err=0; then read addr=0x6 → bus addr=0x4.
- Grant stall: slave withholds gnt for 5 cycles → req and fields stable throughout; rsp_valid_o 5 cycles later than the zero-wait case; err=0.
- Timeout: TIMEOUT_CYCLES=8, slave never grants → req drops after 8 cycles in REQ; rsp_err_o=1, rsp_rdata_o=0xBADCAB1E; then a new command is accepted.
- Backpressure and spurious rvalid: hold rsp_ready_i=0 for 4 cycles → response held stable and cmd_ready_o=0; an rvalid pulse during IDLE → no response generated.
- Reset mid-transaction: assert rst_i while in WAIT_RSP → all outputs 0 asynchronously; after release, state is IDLE with cmd_ready_o=1.

Source files
------------

// File: rtl/e_gpu_obi_pkg.sv
// Shared types and constants for the OBI configuration-register initiator.
package e_gpu_obi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

endpackage

// File: rtl/obi_if.sv
// OBI request (A) and response (R) channel bundles used between the initiator and the register slave.
interface obi_req_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;

    modport master (output req, we, be, addr, wdata, input gnt);
    modport slave  (input req, we, be, addr, wdata, output gnt);
endinterface

// Modports are named from the receiving side: "slave" consumes rvalid/rdata.
interface obi_rsp_if;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output rvalid, rdata);
    modport slave  (input rvalid, rdata);
endinterface

// File: rtl/obi_timeout_cnt.sv
// Saturating phase timer: expired is high once TIMEOUT_CYCLES-1 enabled cycles have elapsed since clr.
module obi_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/obi_cfg_initiator.sv
// Single-outstanding OBI initiator: turns host commands into config-register bus accesses with timeout.
module obi_cfg_initiator
    import e_gpu_obi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    obi_req_if.master   regs_req,
    obi_rsp_if.slave    regs_rsp
);

    state_t      state_q;
    cmd_t        cmd_q;
    logic        req_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    // Timer is held clear while idle and restarts when the grant moves us into WAIT_RSP.
    assign tmo_clr = (state_q == IDLE) || ((state_q == REQ) && regs_req.gnt);
    assign tmo_en  = ((state_q == REQ) && !regs_req.gnt) ||
                     ((state_q == WAIT_RSP) && !regs_rsp.rvalid);

    obi_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            req_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_q <= '{we:    cmd_we_i,
                                   be:    cmd_be_i,
                                   addr:  {cmd_addr_i[31:2], 2'b00},
                                   wdata: cmd_wdata_i};
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (regs_req.gnt) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT_RSP;
                    end else if (tmo_expired) begin
                        req_q       <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= ERR_RDATA;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                WAIT_RSP: begin
                    // A response landing on the expiry cycle still counts as a good response.
                    if (regs_rsp.rvalid) begin
                        rsp_rdata_q <= cmd_q.we ? 32'h0 : regs_rsp.rdata;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (tmo_expired) begin
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= ERR_RDATA;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o    = (state_q == IDLE) && !rst_i;
    assign busy_o         = (state_q != IDLE);
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_rdata_o    = rsp_rdata_q;

    assign regs_req.req   = req_q;
    assign regs_req.we    = cmd_q.we;
    assign regs_req.be    = cmd_q.be;
    assign regs_req.addr  = cmd_q.addr;
    assign regs_req.wdata = cmd_q.wdata;

endmodule

// File: tb/tb_obi_cfg_initiator.sv
// Bench for obi_cfg_initiator: behavioural register slave plus a cycle-level expectation model.
module tb_obi_cfg_initiator;

    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hBADCAB1E;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    obi_req_if req_if ();
    obi_rsp_if rsp_if ();

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obi_cfg_initiator #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_addr_i (cmd_addr),
        .cmd_wdata_i(cmd_wdata),
        .cmd_be_i   (cmd_be),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .busy_o     (busy),
        .regs_req   (req_if),
        .regs_rsp   (rsp_if)
    );

    // ---------------- behavioural register slave ----------------
    int          gnt_delay = 0;
    int          rsp_delay = 0;
    bit          never_gnt = 0;
    bit          drop_rsp  = 0;
    logic        spur      = 1'b0;
    int          stall_cnt = 0;
    bit          pend      = 0;
    int          dly       = 0;
    logic        rvalid_q  = 1'b0;
    logic [31:0] rdata_q   = '0;
    logic [31:0] smem [16];

    assign req_if.gnt    = req_if.req && !never_gnt && (stall_cnt >= gnt_delay);
    assign rsp_if.rvalid = rvalid_q | spur;
    assign rsp_if.rdata  = rdata_q;

    always @(posedge clk) begin
        stall_cnt <= (req_if.req && !req_if.gnt) ? stall_cnt + 1 : 0;
        rvalid_q  <= 1'b0;
        if (pend) begin
            if (dly == 0) begin
                rvalid_q <= 1'b1;
                pend     <= 0;
            end else begin
                dly <= dly - 1;
            end
        end
        if (req_if.req && req_if.gnt) begin
            if (req_if.we) begin
                for (int b = 0; b < 4; b++)
                    if (req_if.be[b]) smem[req_if.addr[5:2]][8*b +: 8] <= req_if.wdata[8*b +: 8];
                rdata_q <= '0;
            end else begin
                rdata_q <= smem[req_if.addr[5:2]];
            end
            if (!drop_rsp) begin
                if (rsp_delay == 0) rvalid_q <= 1'b1;
                else begin
                    pend <= 1;
                    dly  <= rsp_delay - 1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [16];

    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int d, input int r, input bit ng,
                       input bit drop, input int bp, input string tag);
        int          exp_lat, exp_req, lat, reqc;
        bit          exp_err, granted, fields_ok, first_req, hold_ok;
        logic [31:0] exp_rdata, exp_addr, cap_rdata;
        logic        cap_err;
        logic [31:0] w;

        gnt_delay = d; rsp_delay = r; never_gnt = ng; drop_rsp = drop;
        exp_addr = {addr[31:2], 2'b00};
        granted  = !ng && (d < T);
        if (!granted) begin
            exp_lat = T + 1; exp_req = T; exp_err = 1;
        end else begin
            exp_req = d + 1;
            if (!drop && r <= T - 1) begin
                exp_lat = 3 + d + r; exp_err = 0;
            end else begin
                exp_lat = 2 + d + T; exp_err = 1;
            end
            if (we) begin
                w = ref_mem[addr[5:2]];
                for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
                ref_mem[addr[5:2]] = w;
            end
        end
        exp_rdata = exp_err ? ERR : (we ? 32'h0 : ref_mem[addr[5:2]]);

        @(negedge clk);
        cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be; cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s cmd_ready: got %b want 1", tag, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1; reqc = 0; fields_ok = 1; first_req = (req_if.req === 1'b1);
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (req_if.req === 1'b1) begin
                reqc++;
                if (req_if.addr !== exp_addr || req_if.we !== we || req_if.be !== be ||
                    req_if.wdata !== wdata) fields_ok = 0;
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!first_req) begin
            errors++; $display("FAIL %s req_in_N+1: got %b want 1", tag, first_req);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
        end
        checks++;
        if (reqc != exp_req || !fields_ok) begin
            errors++; $display("FAIL %s req_cycles/fields: got %0d ok=%0b want %0d ok=1", tag, reqc, fields_ok, exp_req);
        end
        checks++;
        if (rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
            errors++; $display("FAIL %s rsp: got rdata=%h err=%b want rdata=%h err=%b",
                               tag, rsp_rdata, rsp_err, exp_rdata, exp_err);
        end
        cap_rdata = rsp_rdata; cap_err = rsp_err; hold_ok = 1;
        for (int i = 0; i < bp; i++) begin
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_rdata !== cap_rdata ||
                rsp_err !== cap_err) hold_ok = 0;
            @(negedge clk);
        end
        if (bp > 0) begin
            checks++;
            if (!hold_ok) begin
                errors++; $display("FAIL %s backpressure_hold: got unstable want stable", tag);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s return_idle: got valid=%b busy=%b ready=%b want 0 0 1",
                               tag, rsp_valid, busy, cmd_ready);
        end
        never_gnt = 0; drop_rsp = 0; gnt_delay = 0; rsp_delay = 0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (rsp_valid !== 0 || rsp_err !== 0 || rsp_rdata !== 0 || busy !== 0 ||
            req_if.req !== 0 || req_if.we !== 0 || req_if.be !== 0 ||
            req_if.addr !== 0 || req_if.wdata !== 0) begin
            errors++;
            $display("FAIL %s outputs: got valid=%b err=%b rdata=%h busy=%b req=%b we=%b be=%h addr=%h wdata=%h want all 0",
                     tag, rsp_valid, rsp_err, rsp_rdata, busy, req_if.req, req_if.we,
                     req_if.be, req_if.addr, req_if.wdata);
        end
    endtask

    task automatic test_reset();
        #2;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release cmd_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        txn(1, 32'h0, 32'h1, 4'hF, 0, 0, 0, 0, 0, "write_zero_wait");
        checks++;
        if (smem[0][0] !== 1'b1) begin
            errors++; $display("FAIL gpu_start: got %b want 1", smem[0][0]);
        end
    endtask

    task automatic test_readback();
        txn(0, 32'h0, 32'h0, 4'hF, 0, 0, 0, 0, 0, "readback_0");
        txn(0, 32'h6, 32'h0, 4'hF, 0, 0, 0, 0, 0, "read_unaligned");
    endtask

    task automatic test_grant_stall();
        txn(1, 32'h8, 32'hCAFE_F00D, 4'b0101, 5, 0, 0, 0, 0, "grant_stall_wr");
        txn(0, 32'h8, 32'h0, 4'hF, 5, 0, 0, 0, 0, "grant_stall_rd");
    endtask

    task automatic test_timeout();
        txn(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 0, 0, "timeout_req");
        txn(0, 32'h10, 32'h0, 4'hF, 0, 0, 0, 0, 0, "after_timeout");
        txn(0, 32'h0, 32'h0, 4'hF, 0, 0, 0, 1, 0, "timeout_wait_rsp");
        txn(0, 32'h8, 32'h0, 4'hF, 0, T - 1, 0, 0, 0, "rvalid_on_expiry");
        txn(0, 32'h8, 32'h0, 4'hF, 0, T, 0, 0, 0, "rvalid_after_expiry");
        txn(0, 32'h8, 32'h0, 4'hF, T - 1, 0, 0, 0, 0, "gnt_last_cycle");
    endtask

    task automatic test_backpressure_spurious();
        bit quiet;
        txn(0, 32'h0, 32'h0, 4'hF, 1, 2, 0, 0, 4, "backpressure");
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        quiet = 1;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) quiet = 0;
            @(negedge clk);
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL spurious_rvalid: got response/busy want idle");
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                0, 0, $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_reset_mid_txn();
        drop_rsp = 1;
        @(negedge clk);
        cmd_we = 0; cmd_addr = 32'h4; cmd_be = 4'hF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || req_if.req !== 1'b0) begin
            errors++; $display("FAIL mid_txn_wait: got busy=%b req=%b want 1 0", busy, req_if.req);
        end
        #1 rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        rst = 1'b0;
        drop_rsp = 0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL after_reset: got ready=%b busy=%b valid=%b want 1 0 0",
                               cmd_ready, busy, rsp_valid);
        end
        txn(0, 32'h0, 32'h0, 4'hF, 0, 0, 0, 0, 0, "post_reset_read");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            smem[i]    = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_write_zero_wait();
        test_readback();
        test_grant_stall();
        test_timeout();
        test_backpressure_spurious();
        test_random();
        test_reset_mid_txn();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
